// File: rtl/cam_pkg.sv
// Shared definitions for the DVP camera path: FSM states, default OV7670
// timing, RGB444 byte packing and the colour-bar palette. The capture block
// uses the same packing functions so both sides agree on byte order.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } tx_state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BLANK     = 288;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_V_FRONT     = 10;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  // First byte on the bus carries red in the low nibble.
  function automatic logic [7:0] pack_byte0(input logic [11:0] pix);
    return {4'b0000, pix[11:8]};
  endfunction

  // Second byte carries green (high nibble) and blue (low nibble).
  function automatic logic [7:0] pack_byte1(input logic [11:0] pix);
    return pix[7:0];
  endfunction

  // Colour of bar 0..7, left to right.
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_tx_timing.sv
// Frame/line timing generator for the DVP transmitter. Owns the horizontal
// counter, the line-within-state counter and the state register. All decode
// outputs are combinational from registered state; the top registers them.
// Optional macro CAM_TX_TEST_PATTERN_EN adds the colour-bar index output.
module cam_tx_timing
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  output tx_state_t state,
  output logic      data_region,
  output logic      rd_strobe,
  output logic      byte_phase,
  output logic      frame_end
`ifdef CAM_TX_TEST_PATTERN_EN
  ,
  output logic [2:0] bar_idx
`endif
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HW = $clog2(LINE_LEN);
  localparam int LW = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

  localparam logic [HW-1:0] H_LAST       = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_STROBE0    = HW'(LINE_LEN - 2);
  localparam logic [HW-1:0] H_DATA       = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0] H_STROBE_MAX = HW'(2 * H_ACTIVE - 2);

  tx_state_t     state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [LW-1:0] state_lines;
  logic          line_end;
  logic          last_line;

  assign line_end  = (hcnt_q == H_LAST);
  assign last_line = (lcnt_q == state_lines - LW'(1));

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Number of lines spent in the current state.
  always_comb begin
    state_lines = LW'(1);
    case (state_q)
      ST_VSYNC:  state_lines = LW'(VSYNC_LINES);
      ST_VBACK:  state_lines = LW'(V_BACK);
      ST_ACTIVE: state_lines = LW'(V_ACTIVE);
      ST_VFRONT: state_lines = LW'(V_FRONT);
      default:   state_lines = LW'(1);
    endcase
  end

  // Next-state and counter advance; start is only looked at in IDLE and at
  // the very end of the front porch, so dropping it never truncates a frame.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    if (state_q == ST_IDLE) begin
      hcnt_d = '0;
      lcnt_d = '0;
      if (start) state_d = ST_VSYNC;
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
      if (line_end) begin
        if (last_line) begin
          lcnt_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            ST_VFRONT: state_d = start ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
    end
  end

  // Pixel p's first byte is decoded at hcnt=2p; its read strobe is decoded
  // two counts earlier, which for p=0 lands at LINE_LEN-2 of the previous
  // line (last VBACK line or a non-final ACTIVE line).
  assign state       = state_q;
  assign data_region = (state_q == ST_ACTIVE) && (hcnt_q < H_DATA);
  assign byte_phase  = hcnt_q[0];
  assign frame_end   = (state_q == ST_VFRONT) && last_line && line_end;
  assign rd_strobe   = ((state_q == ST_ACTIVE) && !hcnt_q[0] && (hcnt_q < H_STROBE_MAX)) ||
                       ((hcnt_q == H_STROBE0) &&
                        (((state_q == ST_VBACK) && last_line) ||
                         ((state_q == ST_ACTIVE) && !last_line)));

`ifdef CAM_TX_TEST_PATTERN_EN
  int col8;
  // Bar index of the current column: col*8/H_ACTIVE gives 8 equal bars.
  always_comb begin
    col8    = ((int'(hcnt_q) >> 1) * 8) / H_ACTIVE;
    bar_idx = col8[2:0];
  end
`endif

endmodule

// File: rtl/cam_dvp_tx.sv
// OV7670-style DVP transmitter: fetches 12-bit RGB444 pixels from a frame
// memory and sends them as two bytes per pixel with vsync/href timing.
// Optional macro CAM_TX_TEST_PATTERN_EN replaces the memory with 8 vertical
// colour bars and holds o_rd_en low; timing is identical in both builds.
// Memory handshake: o_rd_en is a one-cycle strobe with o_rd_addr valid in the
// same cycle; i_rd_data must be valid exactly one cycle later. No backpressure.
module cam_dvp_tx
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic        i_pclk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [18:0] o_rd_addr,
  output logic        o_rd_en,
  input  logic [11:0] i_rd_data,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_D,
  output logic        o_frame_done,
  output tx_state_t   dbg_state
);

  tx_state_t   state;
  logic        data_region;
  logic        rd_strobe;
  logic        byte_phase;
  logic        frame_end;
  logic [11:0] src_pix;
  logic [11:0] pix_q;
`ifdef CAM_TX_TEST_PATTERN_EN
  logic [2:0]  bar_idx;
`endif

  cam_tx_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .clk         (i_pclk),
    .rst_n       (i_rstn),
    .start       (i_start),
    .state       (state),
    .data_region (data_region),
    .rd_strobe   (rd_strobe),
    .byte_phase  (byte_phase),
    .frame_end   (frame_end)
`ifdef CAM_TX_TEST_PATTERN_EN
    ,
    .bar_idx     (bar_idx)
`endif
  );

  assign dbg_state = state;

  // Pixel source for the byte-0 cycle: memory data or the bar generator.
  always_comb begin
`ifdef CAM_TX_TEST_PATTERN_EN
    src_pix = bar_color(bar_idx);
`else
    src_pix = i_rd_data;
`endif
  end

  // Registered outputs, address counter and held pixel for byte 1.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_vsync      <= 1'b0;
      o_href       <= 1'b0;
      o_D          <= 8'h00;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_frame_done <= 1'b0;
      pix_q        <= '0;
    end else begin
      o_vsync      <= (state == ST_VSYNC);
      o_href       <= data_region;
      o_frame_done <= frame_end;
`ifdef CAM_TX_TEST_PATTERN_EN
      o_rd_en      <= 1'b0;
`else
      o_rd_en      <= rd_strobe;
`endif
      // No strobes happen during VSYNC, so clearing throughout it is safe.
      if (state == ST_VSYNC) begin
        o_rd_addr <= '0;
      end else if (o_rd_en) begin
        o_rd_addr <= o_rd_addr + 19'd1;
      end
      if (data_region) begin
        if (!byte_phase) begin
          o_D   <= pack_byte0(src_pix);
          pix_q <= src_pix;
        end else begin
          o_D   <= pack_byte1(pix_q);
        end
      end else begin
        o_D <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Bench for cam_dvp_tx with small frame parameters (4x2 pixels, 12-cycle
// lines, 60-cycle frames). A synchronous memory model answers reads; a
// monitor collects every href byte and checks strobe lead and line length.
module tb_cam_dvp_tx;
  import cam_pkg::*;

  localparam int TH    = 4;
  localparam int TV    = 2;
  localparam int TB    = 4;
  localparam int TVS   = 1;
  localparam int TVB   = 1;
  localparam int TVF   = 1;
  localparam int LINE  = 2 * TH + TB;
  localparam int FRAME = (TVS + TVB + TV + TVF) * LINE;
  localparam int NPIX  = TH * TV;
`ifdef CAM_TX_TEST_PATTERN_EN
  localparam int EXP_RD = 0;
`else
  localparam int EXP_RD = NPIX;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] rd_data = 12'h000;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        frame_done;
  tx_state_t   dbg_state;

  cam_dvp_tx #(
    .H_ACTIVE(TH), .V_ACTIVE(TV), .H_BLANK(TB),
    .VSYNC_LINES(TVS), .V_BACK(TVB), .V_FRONT(TVF)
  ) dut (
    .i_pclk(clk), .i_rstn(rst_n), .i_start(start),
    .o_rd_addr(rd_addr), .o_rd_en(rd_en), .i_rd_data(rd_data),
    .o_vsync(vsync), .o_href(href), .o_D(d),
    .o_frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- memory model (1-cycle read latency) ----------------
  logic [11:0] mem [NPIX];
  always @(posedge clk) begin
    if (rd_en) rd_data <= (int'(rd_addr) < NPIX) ? mem[int'(rd_addr)] : 12'hBAD;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] got_q[$];
  int rd_cnt = 0;
  int fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD;
  endfunction

  // ---------------- monitor ----------------
  logic rd_d1 = 1'b0, rd_d2 = 1'b0, href_prev = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0; rd_d1 = 1'b0; rd_d2 = 1'b0; href_prev = 1'b0;
    end else begin
      if (href) begin
        got_q.push_back(d);
`ifndef CAM_TX_TEST_PATTERN_EN
        if (run % 2 == 0) check("rd_lead", {31'h0, rd_d2}, 32'd1);
`endif
        run++;
      end else if (href_prev) begin
        check("href_len", run, 2 * TH);
        run = 0;
      end
      if (rd_en) rd_cnt++;
      if (frame_done) fd_cnt++;
      rd_d2 = rd_d1; rd_d1 = rd_en; href_prev = href;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [11:0] bench_bar(input int b);
    case (b)
      0: return 12'hFFF; 1: return 12'hFF0; 2: return 12'h0FF; 3: return 12'h0F0;
      4: return 12'hF0F; 5: return 12'hF00; 6: return 12'h00F; default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] exp_pix(input int p);
`ifdef CAM_TX_TEST_PATTERN_EN
    return bench_bar(((p % TH) * 8) / TH);
`else
    return mem[p];
`endif
  endfunction

  task automatic check_frame_model(input string name);
    logic [7:0] exp_q[$];
    logic [11:0] pix;
    for (int p = 0; p < NPIX; p++) begin
      pix = exp_pix(p);
      exp_q.push_back({4'h0, pix[11:8]});
      exp_q.push_back(pix[7:0]);
    end
    check({name, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check({name, "_byte"}, got_at(i), {24'h0, exp_q[i]});
    check({name, "_rd_cnt"}, rd_cnt, EXP_RD);
    check({name, "_fd_cnt"}, fd_cnt, 1);
  endtask

  task automatic new_frame_data();
    for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom_range(0, 4095));
    got_q.delete();
    rd_cnt = 0;
    fd_cnt = 0;
  endtask

  // ---------------- bounded waits ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0: return vsync;
      1: return href;
      default: return frame_done;
    endcase
  endfunction

  task automatic wait_rise(input int sel, input int budget, input string name, output int at_cyc);
    logic prev, cur;
    prev = sig(sel);
    at_cyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      cur = sig(sel);
      if (cur && !prev) begin
        at_cyc = cyc;
        #1;
        return;
      end
      prev = cur;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no rising edge within %0d cycles", name, budget);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [11:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t tbl [NPIX];

  initial begin
    int t_v, t_fd, t_h, prev_fd;
    logic seen;

    tbl[0] = '{12'h000, 8'h00, 8'h00};
    tbl[1] = '{12'hFFF, 8'h0F, 8'hFF};
    tbl[2] = '{12'h123, 8'h01, 8'h23};
    tbl[3] = '{12'hA5C, 8'h0A, 8'h5C};
    tbl[4] = '{12'h0F0, 8'h00, 8'hF0};
    tbl[5] = '{12'hF0F, 8'h0F, 8'h0F};
    tbl[6] = '{12'h800, 8'h08, 8'h00};
    tbl[7] = '{12'h001, 8'h00, 8'h01};

    // reset state
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vsync", {31'h0, vsync}, 0);
    check("rst_href", {31'h0, href}, 0);
    check("rst_d", {24'h0, d}, 0);
    check("rst_rd_en", {31'h0, rd_en}, 0);
    check("rst_addr", {13'h0, rd_addr}, 0);
    check("rst_fd", {31'h0, frame_done}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    check("idle_vsync", {31'h0, vsync}, 0);

    // table-driven frame
    for (int i = 0; i < NPIX; i++) mem[i] = tbl[i].data;
    got_q.delete(); rd_cnt = 0; fd_cnt = 0;
    start = 1'b1;
    wait_rise(0, 10, "first_vsync", t_v);
    check("addr_at_vsync", {13'h0, rd_addr}, 0);
    wait_rise(2, FRAME + 5, "frame1_done", t_fd);
`ifndef CAM_TX_TEST_PATTERN_EN
    check("tbl_nbytes", got_q.size(), 2 * NPIX);
    for (int i = 0; i < NPIX; i++) begin
      check("tbl_b0", got_at(2 * i), {24'h0, tbl[i].b0});
      check("tbl_b1", got_at(2 * i + 1), {24'h0, tbl[i].b1});
    end
    check("tbl_rd_cnt", rd_cnt, NPIX);
    check("tbl_fd_cnt", fd_cnt, 1);
`else
    check_frame_model("bars");
`endif
    check("addr_at_done", {13'h0, rd_addr}, EXP_RD);
    prev_fd = t_fd;

    // back-to-back random frames
    for (int f = 0; f < 4; f++) begin
      new_frame_data();
      wait_rise(0, 4, "vsync_after_done", t_v);
      check("vsync_gap", t_v - prev_fd, 1);
      check("addr_new_frame", {13'h0, rd_addr}, 0);
      wait_rise(2, FRAME + 5, "rand_done", t_fd);
      check("frame_len", t_fd - prev_fd, FRAME);
      check_frame_model("rand");
      prev_fd = t_fd;
    end

    // start dropped mid-ACTIVE: frame completes, then idle
    new_frame_data();
    wait_rise(1, FRAME, "href_rise_drop", t_h);
    start = 1'b0;
    wait_rise(2, FRAME + 5, "drop_done", t_fd);
    check("drop_len", t_fd - prev_fd, FRAME);
    check_frame_model("drop");
    check("drop_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    seen = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (vsync || frame_done || href) seen = 1'b1;
    end
    check("no_activity_after_drop", {31'h0, seen}, 0);

    // reset in the middle of an active line
    start = 1'b1;
    wait_rise(1, FRAME, "href_rise_rst", t_h);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vsync", {31'h0, vsync}, 0);
    check("mid_rst_href", {31'h0, href}, 0);
    check("mid_rst_d", {24'h0, d}, 0);
    check("mid_rst_rd_en", {31'h0, rd_en}, 0);
    check("mid_rst_addr", {13'h0, rd_addr}, 0);
    check("mid_rst_fd", {31'h0, frame_done}, 0);
    check("mid_rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    repeat (2) @(negedge clk);
    new_frame_data();
    rst_n = 1'b1;
    wait_rise(0, 4, "vsync_after_rst", t_v);
    check("post_rst_addr", {13'h0, rd_addr}, 0);
    start = 1'b0;
    wait_rise(2, FRAME + 5, "post_rst_done", t_fd);
    check("post_rst_len", t_fd - t_v, FRAME - 1);
    check_frame_model("post_rst");
    repeat (2) @(negedge clk);
    check("final_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
